// File: rtl/inst_fetch_pkg.sv
// Shared ISA constants for the fetch, ROM and decode stages.
// Opcodes, instruction field positions and the fetch buffer entry layout.
package inst_fetch_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_LDI  = 4'd3,
    OP_INC  = 4'd4,
    OP_DEC  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_BEQ  = 4'd8,
    OP_BNE  = 4'd9,
    OP_GOTO = 4'd10,
    OP_LD   = 4'd11,
    OP_ST   = 4'd12,
    OP_AND  = 4'd13,
    OP_OR   = 4'd14,
    OP_XOR  = 4'd15
  } opcode_e;

  localparam int INST_W  = 16;
  localparam int PC_W    = 8;
  localparam int ENTRY_W = PC_W + INST_W;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int DEST_MSB = 11;
  localparam int DEST_LSB = 8;
  localparam int OP1_MSB  = 7;
  localparam int OP1_LSB  = 4;
  localparam int OP2_MSB  = 3;
  localparam int OP2_LSB  = 0;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  localparam logic [INST_W-1:0] INST_NOP = '0;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry circular FIFO of {pc, inst} words.
// Flush wins over push/pop; an empty head reads as all zeros.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [ENTRY_W-1:0]     din_i,
  output logic [ENTRY_W-1:0]     dout_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      rd_q, rd_d;
  logic [PW-1:0]      wr_q, wr_d;
  logic [PW:0]        cnt_q, cnt_d;
  logic               do_push;
  logic               do_pop;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    do_pop  = pop_i && (cnt_q != '0) && !flush_i;
    do_push = push_i && !flush_i &&
              ((cnt_q != (PW+1)'(DEPTH)) || do_pop);
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = rd_q + PW'(1);
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + (PW+1)'(1);
      if (do_pop && !do_push) cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents need no reset since count gates the head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: BOOT/FETCH/HALT control, PC and fetch buffer.
// Redirects flush and restart; halt stops fetching while drain continues.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [3:0]        out_op,
  output logic [3:0]        out_dest,
  output logic [3:0]        out_op1,
  output logic [3:0]        out_op2,
  output logic [7:0]        out_imm,
  output logic              halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CW-1:0]      count;
  logic               push;
  logic               pop;
  logic               flush;
  logic               has_space;
  logic [ENTRY_W-1:0] head_raw;
  fetch_entry_t       head;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({pc_q, rom_inst}),
    .dout_o  (head_raw),
    .count_o (count)
  );

  // Next state, PC and buffer controls; redirect overrides everything.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    push      = 1'b0;
    flush     = 1'b0;
    pop       = out_valid && out_ready;
    has_space = (count != CW'(DEPTH)) || pop;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      state_d = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_BOOT:  state_d = ST_FETCH;
        ST_FETCH: begin
          if (halt_req) begin
            state_d = ST_HALT;
          end else if (has_space) begin
            push = 1'b1;
            pc_d = pc_q + 8'd1;
          end
        end
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign head      = fetch_entry_t'(head_raw);
  assign out_valid = (count != '0);
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
  assign out_op    = head.inst[OP_MSB:OP_LSB];
  assign out_dest  = head.inst[DEST_MSB:DEST_LSB];
  assign out_op1   = head.inst[OP1_MSB:OP1_LSB];
  assign out_op2   = head.inst[OP2_MSB:OP2_LSB];
  assign out_imm   = head.inst[IMM_MSB:IMM_LSB];
  assign halted    = (state_q == ST_HALT);
  assign rom_addr  = pc_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of fetch buffer entries (power of two, 2..4).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rom_addr  output  8  address to the combinational instruction ROM, driven from the fetch PC register.
REQ-005 SHALL have port rom_inst  input  16  ROM data for rom_addr, valid in the same cycle.
REQ-006 SHALL have port redirect_valid  input  1  execute-stage request to restart fetch (R0 written, BEQ/BNE skip, goto).
REQ-007 SHALL have port redirect_pc  input  8  restart address, sampled when redirect_valid=1.
REQ-008 SHALL have port halt_req  input  1  request to stop fetching.
REQ-009 SHALL have port out_valid  output  1  buffer head holds an instruction.
REQ-010 SHALL have port out_ready  input  1  decode/execute accepts the head this cycle.
REQ-011 SHALL have port out_inst  output  16  head instruction word.
REQ-012 SHALL have port out_pc  output  8  address the head was fetched from.
REQ-013 SHALL have ports out_op (4), out_dest (4), out_op1 (4), out_op2 (4), out_imm (8), all outputs: fields of out_inst as [15:12], [11:8], [7:4], [3:0], [7:0].
REQ-014 SHALL have port halted  output  1  state is HALT.

Function
REQ-015 SHALL implement the states BOOT, FETCH and HALT.
REQ-016 SHALL move BOOT->FETCH unconditionally on the first edge with rst=0; no fetch occurs in BOOT.
REQ-017 In FETCH, on each edge where the buffer has space (count<DEPTH, or count==DEPTH with a pop that same edge), SHALL push {pc, rom_inst} and set pc <= pc+1, modulo 256 (255 wraps to 0).
REQ-018 SHALL pop the head on each edge where out_valid && out_ready.
REQ-019 SHALL allow push and pop on the same edge; count is then unchanged.
REQ-020 SHALL drive out_valid = (count!=0); out_inst, out_pc and the field outputs SHALL be combinational from the head entry.
REQ-021 When count==0, out_inst SHALL read 16'h0000 (NOP).
REQ-022 redirect_valid SHALL take priority over push, pop and halt_req in every state: the buffer is flushed (count<=0), pc <= redirect_pc, no push occurs that edge, and the next state is FETCH (this includes leaving HALT).
REQ-023 halt_req in FETCH without redirect SHALL move the block to HALT with no push that edge; pops continue in HALT until the buffer is empty.
REQ-024 halt_req while in HALT SHALL have no effect.
REQ-025 Latency SHALL be: the first out_valid occurs in the cycle after the second edge following rst deassertion; after a redirect, out_valid occurs one cycle after the redirect edge, holding redirect_pc.
REQ-026 rom_addr SHALL equal pc at all times.

Reset
REQ-027 With rst=1 at an edge, the block SHALL set state=BOOT, pc=0, count=0, and the buffer pointers to 0; out_valid=0, halted=0, out_inst=0 and rom_addr=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered instructions and take priority over redirect_valid and halt_req.

Structure
REQ-029 The opcode constants (NOP=0 … XOR=15) and the field bit positions SHALL live in a shared package or include used by both the ROM and the decode stage.
REQ-030 The buffer SHALL be a sub-module fetch_fifo (DEPTH entries × 24 bits; push/pop/flush; count output); the FSM and PC SHALL stay in inst_fetch.

Verification
REQ-031 Reset release with out_ready=1 and ROM word 0 = 16'h3220 -> out_valid first high in the third cycle, with out_pc=0, out_op=3, out_dest=2, out_imm=8'h20; out_pc then increments by 1 every cycle.
REQ-032 out_ready=0 for 5 cycles -> count saturates at DEPTH, pc stops at 2, and no entry is lost or duplicated when out_ready returns to 1.
REQ-033 redirect_valid=1 with redirect_pc=4 while count=2 -> the next cycle shows count=0 and rom_addr=4, and the following cycle shows out_valid=1 with out_pc=4.
REQ-034 redirect_pc=8'hFE with continuous out_ready=1 -> out_pc sequence FE, FF, 00, 01.
REQ-035 halt_req at pc=6 -> halted=1, the buffer drains, and pc holds at 6; a later redirect to 0 -> halted=0 and fetch resumes at 0.
REQ-036 rst=1 asserted while count=2 and halted=0 -> on the next cycle out_valid=0, state=BOOT, and rom_addr=0.
